vga_ball_locator: RTL and testbench
===================================

# vga_ball_locator

Receive-side counterpart of the VGA output path. Consumes a pixel stream with negative-logic HS/VS and 4-bit RGB, recovers the pixel coordinates from the sync pulses, and finds the bounding box of "ball-coloured" pixels each frame. Once per frame it reports the box centre as 10-bit `ball_x`/`ball_y`, the coordinates the VGA display controller consumes for its marker overlay.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `V_ACTIVE`, 480: active lines per frame
- `H_BP`, 48: pixel strobes from HS deassertion to first active pixel
- `V_BP`, 33: lines from VS deassertion to first active line
- `B_MIN`, 12: minimum blue level for a hit
- `RG_MAX`, 3: maximum red and green level for a hit
- `MIN_HITS`, 16: hits required to report found (macro-dependent)

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `rst_n` in 1: synchronous, active-low reset
- `pix_valid` in 1: pixel strobe; HS/VS/RGB are sampled only when high
- `hsync` in 1: horizontal sync, negative logic
- `vsync` in 1: vertical sync, negative logic
- `red`, `green`, `blue` in 4 each: pixel colour
- `ball_x` out 10: bbox centre X
- `ball_y` out 10: bbox centre Y
- `ball_found` out 1: last completed frame contained a valid ball
- `frame_done` out 1: one-cycle pulse when outputs update
- `hit_count` out 16: hit pixels in the last completed frame

## Operation
- Input stage: `pix_valid`, sync and RGB are registered (s1); sync is registered again (s2). Edge detection compares s1 against s2.
- `hcnt` is 11-bit and clears on HS deassertion (s1 high, s2 low). It increments per valid strobe and saturates at 2047.
- `vcnt` is 11-bit and clears on VS deassertion. It increments on each HS assertion and saturates at 2047.
- A pixel is active when `H_BP <= hcnt < H_BP+H_ACTIVE` and `V_BP <= vcnt < V_BP+V_ACTIVE`.
  - x = hcnt−H_BP and y = vcnt−V_BP, truncated to 10 bits.
- A hit is an active valid pixel with blue ≥ `B_MIN`, red ≤ `RG_MAX` and green ≤ `RG_MAX`.
- Per-frame registers:
  - xmin and ymin start at 1023; xmax and ymax start at 0.
  - Each hit updates min/max.
  - hits is a 16-bit counter that saturates at 65535.
- FSM states:
  - SYNC_WAIT: entered at reset. Discards the partial frame. Moves to FRAME on the first VS assertion (s1 low, s2 high) and clears the per-frame registers.
  - FRAME: accumulates hits. On VS assertion it moves to REPORT.
  - REPORT: one cycle.
    - Loads the outputs and pulses `frame_done`.
    - Clears the per-frame registers.
    - Returns to FRAME.
- Report arithmetic:
  - `ball_x` = (xmin+xmax)>>1, with an 11-bit sum and a 10-bit result. `ball_y` is computed the same way.
  - These are loaded only when found; otherwise `ball_x`/`ball_y` hold their previous values.
  - found means hits ≥ 1 when the macro is off, or hits ≥ `MIN_HITS` when it is on.
- A hit and a VS assertion never coincide, since VS lies outside the active region. If they do, the hit is ignored.
- Reset mid-frame returns the block to SYNC_WAIT. The first report after reset follows one complete VS-to-VS frame.

## Timing
- Reset values: `ball_x`=0, `ball_y`=0, `ball_found`=0, `frame_done`=0, `hit_count`=0, FSM in SYNC_WAIT.
- Pixel latency: a pixel sampled at edge N is in s1 after N and updates the bbox at edge N+1.
- Report latency:
  - VS low first sampled at edge N puts the FSM in REPORT after edge N+1.
  - The outputs change and `frame_done` is high in the cycle after edge N+2, for exactly 1 cycle.
- Between `frame_done` pulses all outputs are stable.
- `pix_valid` low freezes the counters and bbox; the sync registers also update only on valid.

## Configuration
- `VGA_BALL_LOCATOR_HITCNT_EN` defined:
  - hits are counted.
  - found requires hits ≥ `MIN_HITS`.
  - `hit_count` reports the saturated count.
- Undefined:
  - The hit counter is removed.
  - found is "any hit" (a 1-bit flag).
  - `hit_count` is tied to 0.

## Structure
- The shared package `vga_pkg` holds:
  - the timing defaults `H_ACTIVE`, `V_ACTIVE`, `H_BP`, `V_BP`
  - the 10/11-bit coordinate width constants
  - the FSM state enum `{SYNC_WAIT, FRAME, REPORT}`
- Sub-module `vga_sync_tracker` holds:
  - input registers, edge detect and `hcnt`/`vcnt`
  - outputs: `active`, `x`, `y`, `vs_assert`, registered RGB
- The top level holds the hit compare, bbox, FSM and output registers.

## Test plan
- Reset held 3 cycles mid-stream → all outputs 0, no `frame_done` until one full frame after the next VS assertion.
- Full frame with blue (R0 G0 BF) square x 100–119, y 200–219, else white → `frame_done` once, `ball_x`=109, `ball_y`=209, `ball_found`=1, `hit_count`=400 (macro on).
- Next frame all white → `ball_found`=0, `ball_x`/`ball_y` hold 109/209, `hit_count`=0.
- Macro on, 8-pixel blue blob (< `MIN_HITS`) → `ball_found`=0. Macro off, same stimulus → `ball_found`=1.
- Single hit pixels at (0,0) and (639,479) → `ball_x`=319, `ball_y`=239. A blue pixel at hcnt=`H_BP`−1 (porch) → not counted.
- `pix_valid` toggled 50% across a frame with the square from the second scenario → identical results to the continuous case.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA receive-side constants, pixel payload type and locator FSM states.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned CNT_W    = 11;
  localparam int unsigned COLOR_W  = 4;
  localparam int unsigned HIT_W    = 16;

  localparam int unsigned B_MIN    = 12;
  localparam int unsigned RG_MAX   = 3;
  localparam int unsigned MIN_HITS = 16;

  typedef enum logic [1:0] {SYNC_WAIT, FRAME, REPORT} state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb_t;

  // Strong blue with little red/green marks a ball pixel.
  function automatic logic is_ball_colour(rgb_t c);
    return (c.blue >= COLOR_W'(B_MIN)) &&
           (c.red <= COLOR_W'(RG_MAX)) &&
           (c.green <= COLOR_W'(RG_MAX));
  endfunction

endpackage

// File: rtl/vga_ball_locator_if.sv
// Pixel stream in and per-frame ball report out of the ball locator.
interface vga_ball_locator_if;
  import vga_pkg::*;

  logic               pix_valid;
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic               ball_found;
  logic               frame_done;
  logic [HIT_W-1:0]   hit_count;

  modport master (
    output pix_valid, hsync, vsync, red, green, blue,
    input  ball_x, ball_y, ball_found, frame_done, hit_count
  );

  modport slave (
    input  pix_valid, hsync, vsync, red, green, blue,
    output ball_x, ball_y, ball_found, frame_done, hit_count
  );

endinterface

// File: rtl/vga_sync_tracker.sv
// Registers the pixel stream, detects sync edges and recovers the coordinate of the pixel in s1.
// active/x/y/vs_assert describe the s1 pixel and are combinational; rgb is the s1 colour register.
module vga_sync_tracker
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic               hsync,
  input  logic               vsync,
  input  rgb_t               pix,
  output logic               active,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               vs_assert,
  output rgb_t               rgb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_BP);
  localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_BP);
  localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_BP + V_ACTIVE);

  logic             s1_valid, s1_hs, s1_vs, s2_hs, s2_vs;
  logic             hs_assert, hs_deassert, vs_deassert;
  logic [CNT_W-1:0] hcnt, vcnt, pix_h, pix_v;

  // s2 only advances behind a valid s1 sample, so gaps in the stream never fake an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s2_hs    <= 1'b1;
      s2_vs    <= 1'b1;
      rgb      <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_hs <= hsync;
        s1_vs <= vsync;
        rgb   <= pix;
      end
      if (s1_valid) begin
        s2_hs <= s1_hs;
        s2_vs <= s1_vs;
        hcnt  <= pix_h;
        vcnt  <= pix_v;
      end
    end
  end

  // Coordinate of the s1 pixel; a sync deassertion pixel is coordinate 0 and clearing wins.
  always_comb begin
    hs_assert   = s1_valid && !s1_hs && s2_hs;
    hs_deassert = s1_valid && s1_hs && !s2_hs;
    vs_assert   = s1_valid && !s1_vs && s2_vs;
    vs_deassert = s1_valid && s1_vs && !s2_vs;

    if (hs_deassert)          pix_h = '0;
    else if (hcnt == CNT_MAX) pix_h = hcnt;
    else                      pix_h = hcnt + CNT_W'(1);

    if (vs_deassert)                       pix_v = '0;
    else if (hs_assert && vcnt != CNT_MAX) pix_v = vcnt + CNT_W'(1);
    else                                   pix_v = vcnt;

    active = s1_valid && (pix_h >= H_LO) && (pix_h < H_HI) &&
             (pix_v >= V_LO) && (pix_v < V_HI);
    x      = COORD_W'(pix_h - H_LO);
    y      = COORD_W'(pix_v - V_LO);
  end

endmodule

// File: rtl/vga_ball_locator.sv
// Finds the bounding box of ball-coloured pixels each VS-to-VS frame and reports its centre.
// Define VGA_BALL_LOCATOR_HITCNT_EN for a saturating hit counter with a MIN_HITS threshold.
module vga_ball_locator
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  vga_ball_locator_if.slave bus
);

  state_t             state, state_nxt;
  rgb_t               pix, rgb;
  logic               active, vs_assert, hit;
  logic               accum, clear_frame, load_report, found_c;
  logic [COORD_W-1:0] x, y, xmin, xmax, ymin, ymax;
  logic [COORD_W-1:0] centre_x_c, centre_y_c;
  logic [HIT_W-1:0]   hit_count_c;
  logic [COORD_W-1:0] ball_x_q, ball_y_q;
  logic               ball_found_q, frame_done_q;
  logic [HIT_W-1:0]   hit_count_q;

  assign pix = '{red: bus.red, green: bus.green, blue: bus.blue};

  vga_sync_tracker u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (bus.pix_valid),
    .hsync     (bus.hsync),
    .vsync     (bus.vsync),
    .pix       (pix),
    .active    (active),
    .x         (x),
    .y         (y),
    .vs_assert (vs_assert),
    .rgb       (rgb)
  );

  assign hit = active && is_ball_colour(rgb);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SYNC_WAIT;
    else        state <= state_nxt;
  end

  // A hit coinciding with VS assertion is dropped; REPORT clears the frame for the next one.
  always_comb begin
    state_nxt   = state;
    accum       = 1'b0;
    clear_frame = 1'b0;
    load_report = 1'b0;
    unique case (state)
      SYNC_WAIT: begin
        if (vs_assert) begin
          state_nxt   = FRAME;
          clear_frame = 1'b1;
        end
      end
      FRAME: begin
        if (vs_assert) state_nxt = REPORT;
        else           accum     = hit;
      end
      REPORT: begin
        state_nxt   = FRAME;
        load_report = 1'b1;
        clear_frame = 1'b1;
      end
      default: state_nxt = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_frame) begin
      xmin <= '1;
      ymin <= '1;
      xmax <= '0;
      ymax <= '0;
    end else if (accum) begin
      if (x < xmin) xmin <= x;
      if (x > xmax) xmax <= x;
      if (y < ymin) ymin <= y;
      if (y > ymax) ymax <= y;
    end
  end

`ifdef VGA_BALL_LOCATOR_HITCNT_EN
  logic [HIT_W-1:0] hits;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_frame)      hits <= '0;
    else if (accum && hits != '1)   hits <= hits + HIT_W'(1);
  end

  assign found_c     = hits >= HIT_W'(MIN_HITS);
  assign hit_count_c = hits;
`else
  logic any_hit;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_frame) any_hit <= 1'b0;
    else if (accum)            any_hit <= 1'b1;
  end

  assign found_c     = any_hit;
  assign hit_count_c = '0;
`endif

  assign centre_x_c = COORD_W'(({1'b0, xmin} + {1'b0, xmax}) >> 1);
  assign centre_y_c = COORD_W'(({1'b0, ymin} + {1'b0, ymax}) >> 1);

  // Centre only moves on a found frame so the overlay marker stays put otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ball_x_q     <= '0;
      ball_y_q     <= '0;
      ball_found_q <= 1'b0;
      frame_done_q <= 1'b0;
      hit_count_q  <= '0;
    end else begin
      frame_done_q <= load_report;
      if (load_report) begin
        ball_found_q <= found_c;
        hit_count_q  <= hit_count_c;
        if (found_c) begin
          ball_x_q <= centre_x_c;
          ball_y_q <= centre_y_c;
        end
      end
    end
  end

  assign bus.ball_x     = ball_x_q;
  assign bus.ball_y     = ball_y_q;
  assign bus.ball_found = ball_found_q;
  assign bus.frame_done = frame_done_q;
  assign bus.hit_count  = hit_count_q;

endmodule

// File: tb/tb_vga_ball_locator.sv
// Scoreboard bench for vga_ball_locator: directed frames queue expected reports, a monitor checks them.
module tb_vga_ball_locator;
  import vga_pkg::*;

  localparam int SQ = 0, WHITE = 1, BLOB = 2, CORNER = 3;

  typedef struct {
    int unsigned bx;
    int unsigned by;
    int unsigned hc;
    bit          found;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_ball_locator_if bus ();

  vga_ball_locator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        q[$];
  exp_t        pending, got;
  bit          pending_valid = 1'b0;
  bit          tog_mode = 1'b0;
  int          checks = 0, passed = 0;
  int unsigned held_x = 0, held_y = 0;
  int unsigned stable_err = 0;
  logic [COORD_W-1:0] last_x = '0, last_y = '0;
  logic               last_found = 1'b0;
  logic [HIT_W-1:0]   last_hc = '0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: pops an expectation on every frame_done; otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_x = '0; last_y = '0; last_found = 1'b0; last_hc = '0;
    end else if (bus.frame_done) begin
      if (q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        got = q.pop_front();
        check("ball_x", bus.ball_x, got.bx);
        check("ball_y", bus.ball_y, got.by);
        check("ball_found", bus.ball_found, got.found);
        check("hit_count", bus.hit_count, got.hc);
        check("report_latency_cycle", cyc, got.due);
      end
      last_x = bus.ball_x; last_y = bus.ball_y;
      last_found = bus.ball_found; last_hc = bus.hit_count;
    end else if (bus.ball_x != last_x || bus.ball_y != last_y ||
                 bus.ball_found != last_found || bus.hit_count != last_hc) begin
      stable_err++;
    end
  end

  // Hand-computed per-frame results; centre held when not found.
  function automatic exp_t make_exp(input int scn);
    exp_t e;
    int unsigned hits, cx, cy;
    case (scn)
      SQ:      begin hits = 400; cx = 109; cy = 209; end
      BLOB:    begin hits = 8;   cx = 303; cy = 50;  end
      CORNER:  begin hits = 18;  cx = 319; cy = 239; end
      default: begin hits = 0;   cx = 0;   cy = 0;   end
    endcase
`ifdef VGA_BALL_LOCATOR_HITCNT_EN
    e.found = (hits >= 16);
    e.hc    = hits;
`else
    e.found = (hits >= 1);
    e.hc    = 0;
`endif
    if (e.found) begin held_x = cx; held_y = cy; end
    e.bx  = held_x;
    e.by  = held_y;
    e.due = 0;
    return e;
  endfunction

  // k = hcnt within the line, j = vcnt within the frame.
  function automatic bit want_blue(input int scn, input int k, input int j);
    int x, y;
    bit act;
    x = k - 48;
    y = j - 33;
    act = (k >= 48) && (k < 688) && (j >= 33) && (j < 513);
    case (scn)
      SQ:     return act && x >= 100 && x <= 119 && y >= 200 && y <= 219;
      BLOB:   return act && y == 50 && x >= 300 && x <= 307;
      CORNER: return (act && ((x == 0 && y == 0) || (x == 639 && y == 479) ||
                              (y == 100 && x >= 300 && x <= 315))) ||
                     (k == 47 && j == 43);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int line_len(input int scn, input int j);
    case (scn)
      SQ:     return (j >= 233 && j <= 252) ? 170 : 2;
      BLOB:   return (j == 83) ? 357 : 2;
      CORNER: begin
        if (j == 33 || j == 512) return 690;
        if (j == 133)            return 366;
        if (j == 43)             return 50;
        return 2;
      end
      default: return 2;
    endcase
  endfunction

  function automatic int frame_lines(input int scn);
    case (scn)
      SQ:      return 260;
      BLOB:    return 90;
      CORNER:  return 515;
      default: return 40;
    endcase
  endfunction

  task automatic drive(input logic v, input logic hs, input logic vs,
                       input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    @(negedge clk);
    bus.pix_valid = v;
    bus.hsync     = hs;
    bus.vsync     = vs;
    bus.red       = r;
    bus.green     = g;
    bus.blue      = b;
  endtask

  // In toggle mode each pixel is preceded by an invalid strobe carrying junk sync and blue.
  task automatic send_pix(input logic hs, input logic vs, input bit blue_pix);
    if (tog_mode) drive(1'b0, 1'($urandom), 1'($urandom), 4'h0, 4'h0, 4'hF);
    if (blue_pix) drive(1'b1, hs, vs, 4'h0, 4'h0, 4'hF);
    else          drive(1'b1, hs, vs, 4'hF, 4'hF, 4'hF);
  endtask

  task automatic send_vs_pulse();
    for (int l = 0; l < 2; l++) begin
      send_pix(1'b0, 1'b0, 1'b0);
      if (l == 0 && pending_valid) begin
        pending.due = cyc + 3;
        q.push_back(pending);
        pending_valid = 1'b0;
      end
      for (int k = 0; k < 4; k++) send_pix(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic send_lines(input int scn, input int j0, input int j1);
    for (int j = j0; j <= j1; j++) begin
      send_pix(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < line_len(scn, j); k++)
        send_pix(1'b1, 1'b1, want_blue(scn, k, j));
    end
  endtask

  task automatic send_frame(input int scn, input bit acc);
    send_vs_pulse();
    if (acc) begin
      pending = make_exp(scn);
      pending_valid = 1'b1;
    end
    send_lines(scn, 0, frame_lines(scn) - 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ball_x"}, bus.ball_x, 0);
    check({tag, "_ball_y"}, bus.ball_y, 0);
    check({tag, "_ball_found"}, bus.ball_found, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_hit_count"}, bus.hit_count, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pix_valid = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1;
    bus.red = '0; bus.green = '0; bus.blue = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    send_frame(BLOB, 1'b1);
    send_vs_pulse();
    send_lines(SQ, 0, 99);

    @(negedge clk);
    rst_n = 1'b0;
    bus.pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("midrst");
    held_x = 0; held_y = 0;
    rst_n = 1'b1;
    send_lines(SQ, 100, 259);

    send_frame(SQ, 1'b1);
    send_frame(WHITE, 1'b1);
    send_frame(BLOB, 1'b1);
    send_frame(CORNER, 1'b1);
    tog_mode = 1'b1;
    send_frame(SQ, 1'b1);
    tog_mode = 1'b0;
    send_frame(WHITE, 1'b0);

    @(negedge clk);
    bus.pix_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("missing_frame_done", q.size(), 0);
    check("output_stability_errors", stable_err, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
